// File: rtl/matrix_packer_pkg.sv
// Shared matrix definitions: element and matrix widths, maximum order and
// the packer state encoding used by the packer, determinant and multiplier blocks.
package matrix_packer_pkg;

    localparam int ELEM_W = 8;
    localparam int MAX_N  = 5;
    localparam int MAT_W  = ELEM_W * MAX_N * MAX_N;
    localparam int CNT_W  = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        HOLD = 2'd2
    } pack_state_t;

    function automatic logic size_is_legal(input logic [2:0] n);
        return (n >= 3'd2) && (n <= 3'(MAX_N));
    endfunction

endpackage

// File: rtl/matrix_packer.sv
// Collects an NxN matrix of signed bytes streamed in row-major order and
// presents it, compactly packed from the top bits down, to the determinant units.
module matrix_packer
    import matrix_packer_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [2:0]         size,
    input  logic               clear,
    input  logic               in_valid,
    input  logic [ELEM_W-1:0]  in_data,
    output logic               in_ready,
    output logic [MAT_W-1:0]   out_matrix,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2:0]         out_size,
    output logic               busy,
    output logic               err
);

    pack_state_t      state;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] last_idx;

    assign last_idx  = 5'({2'b00, out_size} * {2'b00, out_size} - 5'd1);
    assign in_ready  = (state == LOAD);
    assign out_valid = (state == HOLD);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            count      <= '0;
            out_matrix <= '0;
            out_size   <= '0;
            err        <= 1'b0;
        end else begin
            err <= 1'b0;
            if (clear) begin
                // An abort beats any start or accept in the same cycle.
                state <= IDLE;
                count <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            if (size_is_legal(size)) begin
                                out_size   <= size;
                                out_matrix <= '0;
                                count      <= '0;
                                state      <= LOAD;
                            end else begin
                                err <= 1'b1;
                            end
                        end
                    end
                    LOAD: begin
                        if (in_valid) begin
                            // Slot is chosen from the counter so the layout stays compact for every N.
                            for (int k = 0; k < MAX_N * MAX_N; k++) begin
                                if (count == 5'(k)) begin
                                    out_matrix[MAT_W-1-ELEM_W*k -: ELEM_W] <= in_data;
                                end
                            end
                            if (count == last_idx) begin
                                state <= HOLD;
                            end else begin
                                count <= count + 5'd1;
                            end
                        end
                    end
                    HOLD: begin
                        if (out_ready) begin
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_matrix_packer.sv
// Self-checking bench for matrix_packer: directed scenarios plus random traffic,
// compared every cycle against a queue-based behavioural model.
module tb_matrix_packer;

    logic         clk;
    logic         rst;
    logic         start;
    logic [2:0]   size;
    logic         clear;
    logic         in_valid;
    logic [7:0]   in_data;
    logic         in_ready;
    logic [199:0] out_matrix;
    logic         out_valid;
    logic         out_ready;
    logic [2:0]   out_size;
    logic         busy;
    logic         err;

    int checks   = 0;
    int failures = 0;

    // Model: phase 0 = idle, 1 = loading, 2 = holding.
    int           mPhase;
    int           mN;
    logic [7:0]   mElems[$];
    logic [199:0] mMatrix;
    logic         mErr;

    matrix_packer dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .size      (size),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_matrix(out_matrix),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_size  (out_size),
        .busy      (busy),
        .err       (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [199:0] observed, input logic [199:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [199:0] packElems();
        logic [199:0] m;
        m = '0;
        foreach (mElems[i]) m = (m << 8) | {192'b0, mElems[i]};
        return m << (8 * (25 - mElems.size()));
    endfunction

    task automatic modelStep();
        mErr = 1'b0;
        if (rst) begin
            mPhase = 0;
            mN     = 0;
            mElems.delete();
            mMatrix = '0;
        end else if (clear) begin
            mPhase = 0;
        end else begin
            case (mPhase)
                0: if (start) begin
                    if (size >= 3'd2 && size <= 3'd5) begin
                        mN = int'(size);
                        mElems.delete();
                        mMatrix = '0;
                        mPhase  = 1;
                    end else begin
                        mErr = 1'b1;
                    end
                end
                1: if (in_valid) begin
                    mElems.push_back(in_data);
                    mMatrix = packElems();
                    if (mElems.size() == mN * mN) mPhase = 2;
                end
                default: if (out_ready) mPhase = 0;
            endcase
        end
    endtask

    // One clock: the model follows the edge, then every output is compared.
    task automatic applyStimulus();
        @(posedge clk);
        modelStep();
        #1;
        checkOutput("in_ready",   {199'b0, in_ready},  {199'b0, mPhase == 1});
        checkOutput("out_valid",  {199'b0, out_valid}, {199'b0, mPhase == 2});
        checkOutput("busy",       {199'b0, busy},      {199'b0, mPhase != 0});
        checkOutput("err",        {199'b0, err},       {199'b0, mErr});
        checkOutput("out_size",   {197'b0, out_size},  {197'b0, 3'(mN)});
        checkOutput("out_matrix", out_matrix,          mMatrix);
    endtask

    task automatic drive(input logic st, input logic [2:0] sz, input logic cl,
                         input logic iv, input logic [7:0] d, input logic ordy);
        start = st; size = sz; clear = cl; in_valid = iv; in_data = d; out_ready = ordy;
        applyStimulus();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 3'd0, 1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        mPhase = 0; mN = 0; mMatrix = '0; mErr = 1'b0;
        drive(1'b0, 3'd0, 1'b0, 1'b0, 8'h00, 1'b0);
        drive(1'b1, 3'd3, 1'b1, 1'b1, 8'h55, 1'b1);
        rst = 1'b0;

        // 2x2 streamed back to back
        drive(1'b1, 3'd2, 1'b0, 1'b0, 8'h00, 1'b0);
        for (int i = 1; i <= 4; i++) drive(1'b0, 3'd0, 1'b0, 1'b1, 8'(i), 1'b0);
        checkOutput("s2_top",  {168'b0, out_matrix[199:168]}, {168'b0, 32'h01020304});
        checkOutput("s2_rest", {32'b0, out_matrix[167:0]}, 200'b0);
        drive(1'b1, 3'd4, 1'b0, 1'b1, 8'h77, 1'b1);
        idle(2);

        // 5x5 with in_valid toggling
        drive(1'b1, 3'd5, 1'b0, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 50; i++) drive(1'b0, 3'd0, 1'b0, 1'((i % 2) == 0), 8'(i / 2 + 1), 1'b0);
        idle(3);
        checkOutput("s5_first", {192'b0, out_matrix[199:192]}, {192'b0, 8'h01});
        checkOutput("s5_last",  {192'b0, out_matrix[7:0]},     {192'b0, 8'h19});
        drive(1'b0, 3'd0, 1'b0, 1'b0, 8'h00, 1'b1);
        idle(1);

        // illegal sizes
        drive(1'b1, 3'd6, 1'b0, 1'b0, 8'h00, 1'b0);
        drive(1'b1, 3'd1, 1'b0, 1'b0, 8'h00, 1'b0);
        idle(1);

        // 3x3 of -128 held for 10 cycles
        drive(1'b1, 3'd3, 1'b0, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 9; i++) drive(1'b0, 3'd0, 1'b0, 1'b1, 8'h80, 1'b0);
        for (int i = 0; i < 10; i++) drive(1'b1, 3'd2, 1'b0, 1'b1, 8'h11, 1'b0);
        checkOutput("s3_neg", {128'b0, out_matrix[199:128]}, {128'b0, {9{8'h80}}});
        drive(1'b0, 3'd0, 1'b0, 1'b0, 8'h00, 1'b1);

        // reset mid-load, then a fresh 2x2
        drive(1'b1, 3'd4, 1'b0, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 7; i++) drive(1'b0, 3'd0, 1'b0, 1'b1, 8'(8'hA0 + i), 1'b0);
        rst = 1'b1;
        drive(1'b0, 3'd0, 1'b0, 1'b1, 8'hEE, 1'b0);
        rst = 1'b0;
        drive(1'b1, 3'd2, 1'b0, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 4; i++) drive(1'b0, 3'd0, 1'b0, 1'b1, 8'(8'hF0 + i), 1'b0);
        checkOutput("s46_low", {32'b0, out_matrix[167:0]}, 200'b0);
        drive(1'b0, 3'd0, 1'b0, 1'b0, 8'h00, 1'b1);

        // clear on the last accept, then restart
        drive(1'b1, 3'd3, 1'b0, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 8; i++) drive(1'b0, 3'd0, 1'b0, 1'b1, 8'(i + 3), 1'b0);
        drive(1'b1, 3'd2, 1'b1, 1'b1, 8'h42, 1'b0);
        idle(3);
        drive(1'b1, 3'd2, 1'b0, 1'b0, 8'h00, 1'b0);
        idle(1);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 79) == 0);
            drive(1'($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)),
                  1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)),
                  8'($urandom), 1'($urandom_range(0, 2) == 0));
        end
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/matrix_packer.md
MATRIX_PACKER -- requirements
Module: matrix_packer

Interface
REQ-001 The module SHALL have the port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The module SHALL have the port rst, input, 1 bit: the reset, which is synchronous and active-high.
REQ-003 The module SHALL have the port start, input, 1 bit: begins a load; it is sampled only in IDLE.
REQ-004 The module SHALL have the port size, input, 3 bits: matrix order N, legal values 2..5; it is sampled with start.
REQ-005 The module SHALL have the port clear, input, 1 bit: synchronous abort back to IDLE.
REQ-006 The module SHALL have the port in_valid, input, 1 bit: an element is present on in_data.
REQ-007 The module SHALL have the port in_data, input, 8 bits, signed two's-complement: the element value.
REQ-008 The module SHALL have the port in_ready, output, 1 bit: the packer can accept an element.
REQ-009 The module SHALL have the port out_matrix, output, 200 bits: the packed matrix for the determinant units.
REQ-010 The module SHALL have the port out_valid, output, 1 bit: out_matrix is complete and stable.
REQ-011 The module SHALL have the port out_ready, input, 1 bit: the consumer has taken the matrix.
REQ-012 The module SHALL have the port out_size, output, 3 bits: the N latched for the matrix being held.
REQ-013 The module SHALL have the port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-014 The module SHALL have the port err, output, 1 bit: a one-cycle pulse flagging an illegal size at start.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, LOAD and HOLD.
REQ-016 In IDLE, start=1 with size in 2..5 SHALL do all of the following on the next edge: latch N into out_size, zero out_matrix, zero the element counter, enter LOAD.
REQ-017 In IDLE, start=1 with size in {0,1,6,7} SHALL pulse err for exactly one cycle and leave the state in IDLE, with no other register changed.
REQ-018 start SHALL be ignored in LOAD and in HOLD.
REQ-019 in_ready SHALL be 1 only in LOAD, and SHALL be driven combinationally from the state.
REQ-020 An element SHALL be accepted on any edge where in_valid and in_ready are both 1.
REQ-021 Accepted element k (0-based, row-major) SHALL be written to out_matrix bits [199-8k : 192-8k]; element (0,0) therefore occupies [199:192].
REQ-022 Packing SHALL be compact row-major for every N: element (r,c) is element k = r*N+c.
REQ-023 All bits above index N*N-1, that is bits [199-8*N*N : 0], SHALL remain zero.
REQ-024 The element counter SHALL be 5 bits wide, count 0..N*N-1, and never wrap in operation.
REQ-025 The acceptance of element N*N-1 SHALL move the FSM to HOLD on that same edge, so out_valid is 1 in the next cycle (latency 1).
REQ-026 In HOLD, out_valid SHALL be 1 and out_matrix and out_size SHALL be held stable.
REQ-027 In HOLD, no element SHALL be accepted, because in_ready is 0.
REQ-028 In HOLD, out_ready=1 SHALL return the FSM to IDLE on the next edge, and out_valid SHALL fall in that cycle.
REQ-029 out_matrix SHALL retain its value in IDLE until the next legal start.
REQ-030 clear=1 in any state SHALL force IDLE and zero the counter; out_matrix is left unchanged and err is not pulsed.
REQ-031 clear and start asserted in the same cycle: clear SHALL win, and the start is dropped.
REQ-032 clear and the last element accepted in the same cycle: clear SHALL win, so the FSM goes to IDLE and never enters HOLD.
REQ-033 out_ready asserted outside HOLD SHALL have no effect.
REQ-034 in_data values SHALL be stored unmodified, with no arithmetic, saturation or sign extension.

Reset
REQ-035 With rst=1 at a clock edge, the following SHALL hold after that edge: state=IDLE, counter=0, out_matrix=0, out_size=0, out_valid=0, in_ready=0, busy=0, err=0.
REQ-036 rst SHALL take priority over clear, start and handshakes, and a reset in LOAD or HOLD SHALL discard the partial or held matrix.

Structure
REQ-037 The constants ELEM_W=8, MAX_N=5, MAT_W=200 and the state encodings (IDLE=0, LOAD=1, HOLD=2) SHALL be defined in the shared matrix definitions package.
REQ-038 Those constants SHALL be shared with the determinant and multiplier blocks.
REQ-039 The block SHALL be a single module with the counter, FSM and packing register inline.
REQ-040 No sub-module is warranted for this block.
REQ-041 The element write position SHALL be computed from the counter, not from a shift register, so that the compact layout holds for every N.

Verification
REQ-042 Scenario: size=2, elements 1,2,3,4 streamed on consecutive cycles -> out_valid 1 cycle after the 4th accept; out_matrix[199:168]=0x01020304, rest 0; out_size=2.
REQ-043 Scenario: size=5, elements 1..25 streamed with in_valid toggling 1/0 -> exactly 25 accepts; [199:192]=0x01, [7:0]=0x19; out_valid held until out_ready, then IDLE.
REQ-044 Scenario: start with size=6, then with size=1 -> err pulses once per start, busy stays 0, out_matrix unchanged.
REQ-045 Scenario: size=3, element 9 stream of -128 (0x80) values, out_ready held 0 for 10 cycles -> out_matrix[199:128]=0x80 repeated 9 times; in_ready=0 and the matrix is stable throughout HOLD.
REQ-046 Scenario: size=4, rst after 7 accepts -> all outputs reset next cycle; a new size=2 load then completes with bits [167:0]=0.
REQ-047 Scenario: size=3, clear asserted in the same cycle as the 9th accept -> state=IDLE, out_valid never rises; a subsequent start is accepted.
